// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer and its synchroniser.
// Holds the sequencer state encoding, the relock counter width and counter sizing.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StFilter,
        StStage,
        StRun
    } state_t;

    localparam int unsigned RELOCK_W = 8;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous reset.
// Also reused by downstream domains to re-time their own domain_rst bit.
module sync_bit #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, filters lock, then releases domain resets in order.
// Lock loss or a lock timeout restarts the PLL and bumps a saturating counter.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_FILTER    = 256,
    parameter int unsigned STAGE_DELAY    = 64,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [RELOCK_W-1:0]    relock_count
);

    localparam int unsigned PW = cnt_w(PLL_RST_CYCLES);
    localparam int unsigned TW = cnt_w(LOCK_TIMEOUT);
    localparam int unsigned FW = cnt_w(LOCK_FILTER);
    localparam int unsigned SW = cnt_w(STAGE_DELAY);
    localparam int unsigned DW = cnt_w(NUM_DOMAINS);
    localparam bit FILT_ONE = (LOCK_FILTER <= 1);

    logic                   locked_s;
    state_t                 state_q, state_d;
    logic [PW-1:0]          rcnt_q, rcnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [FW-1:0]          flt_q, flt_d;
    logic [SW-1:0]          stg_q, stg_d;
    logic [DW-1:0]          idx_q, idx_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic [RELOCK_W-1:0]    relock_q, relock_d;
    logic [TW-1:0]          tmo_inc;
    logic                   tmo_hit;
    logic                   go_relock;
    logic                   go_stage;

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        tmo_d     = tmo_q;
        flt_d     = flt_q;
        stg_d     = stg_q;
        idx_d     = idx_q;
        pll_rst_d = pll_rst_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        relock_d  = relock_q;
        go_relock = 1'b0;
        go_stage  = 1'b0;
        tmo_inc   = tmo_q + TW'(1);
        tmo_hit   = (tmo_inc == TW'(LOCK_TIMEOUT));

        unique case (state_q)
            StPllRst: begin
                if (rcnt_q == PW'(PLL_RST_CYCLES - 1)) begin
                    state_d   = StWaitLock;
                    rcnt_d    = '0;
                    tmo_d     = '0;
                    flt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + PW'(1);
                end
            end

            StWaitLock: begin
                tmo_d = tmo_inc;
                if (tmo_hit) begin
                    go_relock = 1'b1;
                end else if (locked_s) begin
                    if (FILT_ONE) begin
                        go_stage = 1'b1;
                    end else begin
                        state_d = StFilter;
                        flt_d   = FW'(1);
                    end
                end
            end

            StFilter: begin
                tmo_d = tmo_inc;
                // Timeout wins over a filter completing on the same edge.
                if (tmo_hit) begin
                    go_relock = 1'b1;
                end else if (!locked_s) begin
                    state_d = StWaitLock;
                    flt_d   = '0;
                end else if (flt_q + FW'(1) == FW'(LOCK_FILTER)) begin
                    go_stage = 1'b1;
                end else begin
                    flt_d = flt_q + FW'(1);
                end
            end

            StStage: begin
                if (!locked_s) begin
                    go_relock = 1'b1;
                end else if (stg_q == SW'(STAGE_DELAY - 1)) begin
                    stg_d = '0;
                    if (idx_q == DW'(NUM_DOMAINS)) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx_q == DW'(i)) begin
                                dom_d[i] = 1'b0;
                            end
                        end
                        idx_d = idx_q + DW'(1);
                    end
                end else begin
                    stg_d = stg_q + SW'(1);
                end
            end

            StRun: begin
                if (!locked_s) begin
                    go_relock = 1'b1;
                end
            end

            default: begin
                state_d   = StPllRst;
                rcnt_d    = '0;
                pll_rst_d = 1'b1;
                dom_d     = '1;
                ready_d   = 1'b0;
            end
        endcase

        if (go_stage) begin
            state_d  = StStage;
            flt_d    = '0;
            tmo_d    = '0;
            stg_d    = '0;
            idx_d    = DW'(1);
            dom_d[0] = 1'b0;
        end

        if (go_relock) begin
            state_d   = StPllRst;
            rcnt_d    = '0;
            tmo_d     = '0;
            flt_d     = '0;
            stg_d     = '0;
            idx_d     = '0;
            pll_rst_d = 1'b1;
            dom_d     = '1;
            ready_d   = 1'b0;
            relock_d  = (relock_q == '1) ? relock_q : relock_q + RELOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StPllRst;
            rcnt_q    <= '0;
            tmo_q     <= '0;
            flt_q     <= '0;
            stg_q     <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            tmo_q     <= tmo_d;
            flt_q     <= flt_d;
            stg_q     <= stg_d;
            idx_q     <= idx_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            relock_q  <= relock_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst   = dom_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule
